vending_machine: RTL and testbench

//  Coin-accepting vend controller. Sums nickel/dime/quarter insertions into a credit register.

---
 rtl/vending_machine.sv | 74 +++++++
 tb/tb_vending_machine.sv | 122 ++++++++++++
 2 files changed

// File: rtl/vending_machine.sv
// Coin-accepting vend controller: edge-detects nickel/dime/quarter strobes, accumulates
// credit in 5-cent units and pulses valid for one clock per item. Optional macro: VEND_CARRY_EN.
module vending_machine #(
    parameter int PRICE_CENTS = 100,
    parameter int CREDIT_W    = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic nickel,
    input  logic dime,
    input  logic quarter,
    output logic valid
);

    localparam int               PRICE_U = PRICE_CENTS / 5;
    localparam logic [CREDIT_W:0] L_PRICE = PRICE_U[CREDIT_W:0];

    logic                r_prev_n, r_prev_d, r_prev_q;
    logic [CREDIT_W-1:0] r_credit;
    logic                r_valid;

    logic                w_edge_n, w_edge_d, w_edge_q;
    logic [3:0]          w_units;
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W:0]   w_resid;
    logic                w_vend;
    logic [CREDIT_W-1:0] w_credit_nxt;

    assign w_edge_n = nickel  & ~r_prev_n;
    assign w_edge_d = dime    & ~r_prev_d;
    assign w_edge_q = quarter & ~r_prev_q;

    // nickel=1, dime=2, quarter=5 units; simultaneous edges add together (max 8)
    assign w_units = {3'b000, w_edge_n} + {2'b00, w_edge_d, 1'b0} + (w_edge_q ? 4'd5 : 4'd0);
    assign w_sum   = {1'b0, r_credit} + {{(CREDIT_W-3){1'b0}}, w_units};
    assign w_vend  = (w_sum >= L_PRICE);
    assign w_resid = w_sum - L_PRICE;

    always_comb begin
        w_credit_nxt = w_sum[CREDIT_W-1:0];
        if (w_vend) begin
`ifdef VEND_CARRY_EN
            w_credit_nxt = w_resid[CREDIT_W-1:0];
`else
            w_credit_nxt = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_n <= 1'b0;
            r_prev_d <= 1'b0;
            r_prev_q <= 1'b0;
            r_credit <= '0;
            r_valid  <= 1'b0;
        end else begin
            r_prev_n <= nickel;
            r_prev_d <= dime;
            r_prev_q <= quarter;
            r_credit <= w_credit_nxt;
            r_valid  <= w_vend;
        end
    end

    assign valid = r_valid;

`ifndef VEND_CARRY_EN
    // residual only feeds the carry build
    logic w_unused;
    assign w_unused = ^w_resid;
`endif

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: reset, single-coin vends, held coin,
// mixed-coin sequences (carry or forfeit per VEND_CARRY_EN) and async reset mid-credit.
`timescale 1ns/1ps
module tb_vending_machine;

    logic clk = 1'b0;
    logic reset_n;
    logic nickel, dime, quarter;
    logic valid;

    int n_assert = 0;
    int n_fail   = 0;

    vending_machine #(.PRICE_CENTS(100), .CREDIT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .nickel  (nickel),
        .dime    (dime),
        .quarter (quarter),
        .valid   (valid)
    );

    always #1000 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Coins high for one cycle, low for one; valid is checked while the vend pulse is up.
    task automatic pulse(input logic n, input logic d, input logic q, input logic exp_v,
                         input string tag);
        @(negedge clk);
        nickel = n; dime = d; quarter = q;
        @(negedge clk);
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
        chk(tag, {15'd0, valid}, {15'd0, exp_v});
    endtask

    task automatic group(input logic n, input logic d, input logic q, input int cnt,
                         input int vend_at, input int exp_credit, input string tag);
        for (int i = 1; i <= cnt; i++)
            pulse(n, d, q, (i == vend_at), $sformatf("%s_%0d", tag, i));
        chk({tag, "_credit"}, {8'd0, dut.r_credit}, exp_credit[15:0]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        nickel = 1'b0; dime = 1'b0; quarter = 1'b0;
        reset_n = 1'b0;

        // 1. reset and idle
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", {15'd0, valid}, 16'd0);
        end
        chk("rst_credit", {8'd0, dut.r_credit}, 16'd0);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("idle_valid", {15'd0, valid}, 16'd0);
        end

        // 2. single-denomination purchases
        group(1'b0, 1'b0, 1'b1, 4,  4,  0, "q4");
        group(1'b0, 1'b1, 1'b0, 10, 10, 0, "d10");
        group(1'b1, 1'b0, 1'b0, 20, 20, 0, "n20");

        // 3. quarter held high counts once
        @(negedge clk);
        quarter = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_valid", {15'd0, valid}, 16'd0);
        end
        quarter = 1'b0;
        @(negedge clk);
        chk("hold_credit", {8'd0, dut.r_credit}, 16'd5);

        // 4/5. mixed-coin sequence from zero credit
        do_reset();
        chk("seq_start", {8'd0, dut.r_credit}, 16'd0);
`ifdef VEND_CARRY_EN
        group(1'b1, 1'b1, 1'b0, 7, 7, 1,  "nd");
        group(1'b1, 1'b0, 1'b1, 4, 4, 5,  "qn");
        group(1'b0, 1'b1, 1'b1, 3, 3, 6,  "qd");
        group(1'b1, 1'b1, 1'b1, 3, 2, 10, "all");
`else
        group(1'b1, 1'b1, 1'b0, 7, 7, 0, "nd");
        group(1'b1, 1'b0, 1'b1, 4, 4, 0, "qn");
        group(1'b0, 1'b1, 1'b1, 3, 3, 0, "qd");
        group(1'b1, 1'b1, 1'b1, 3, 3, 0, "all");
`endif

        // 6. async reset with 95c banked
        do_reset();
        group(1'b0, 1'b0, 1'b1, 3, 0, 15, "pre_q");
        group(1'b0, 1'b1, 1'b0, 2, 0, 19, "pre_d");
        @(posedge clk);
        #400;
        reset_n = 1'b0;
        #10;
        chk("async_valid",  {15'd0, valid}, 16'd0);
        chk("async_credit", {8'd0, dut.r_credit}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        group(1'b1, 1'b0, 1'b0, 1, 0, 1, "post_n");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
